// File: rtl/gfx_pkg.sv
// Shared constants and types for the graphics memory subsystem.
package gfx_pkg;

  localparam int GFX_WORD_W    = 16;
  localparam int GFX_ADDR_BITS = 14;
  localparam int GFX_MAX_CH    = 8;
  localparam int GFX_CH_W      = $clog2(GFX_MAX_CH);

  typedef logic [GFX_CH_W-1:0] gfx_ch_t;

endpackage

// File: rtl/gfx_spram.sv
// Single-port synchronous RAM with a registered read port, 1-cycle latency.
// The read register only loads on a read access, so it holds between reads.
module gfx_spram
  import gfx_pkg::*;
#(
  parameter int ADDR_BITS = GFX_ADDR_BITS
) (
  input  logic                  CLK,
  input  logic                  RSTb,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_BITS-1:0]  addr,
  input  logic [GFX_WORD_W-1:0] din,
  output logic [GFX_WORD_W-1:0] dout
);

  logic [GFX_WORD_W-1:0] mem [0:(1<<ADDR_BITS)-1];
  logic [GFX_WORD_W-1:0] dout_q;
  logic [GFX_WORD_W-1:0] dout_d;

  always_comb begin
    dout_d = dout_q;
    if (en && !we) dout_d = mem[addr];
  end

  always_ff @(posedge CLK) begin
    if (!RSTb) dout_q <= '0;
    else       dout_q <= dout_d;
  end

  always_ff @(posedge CLK) begin
    if (en && we) mem[addr] <= din;
  end

  assign dout = dout_q;

endmodule

// File: rtl/gfx_memory_arbiter.sv
// Arbitrates N_CH read initiators and one writer onto a single-port SPRAM,
// one access per cycle, with a one-cycle response pipeline.
module gfx_memory_arbiter
  import gfx_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int ADDR_BITS = GFX_ADDR_BITS,
  parameter int STARVE    = 8
) (
  input  logic                  CLK,
  input  logic                  RSTb,
  // Handshake: a requester raises valid with stable address/data and holds it
  // until it sees its one-cycle ready pulse; valid is still high during that
  // ready cycle, and the request it carries there is the one just completed.
  input  logic [16*N_CH-1:0]    rd_addr,
  input  logic [N_CH-1:0]       rd_valid,
  output logic [N_CH-1:0]       rd_ready,
  output logic [GFX_WORD_W-1:0] rd_data,
  input  logic [15:0]           wr_addr,
  input  logic [GFX_WORD_W-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready
);

  localparam int            CW         = $clog2(N_CH);
  localparam logic [CW-1:0] LAST_IDX   = CW'(N_CH - 1);
  localparam logic [3:0]    STARVE_LIM = 4'(STARVE);
  localparam logic [3:0]    STARVE_SAT = 4'hF;

  logic [CW-1:0]         last_ch_q, last_ch_d;
  logic [CW-1:0]         resp_ch_q, resp_ch_d;
  logic [3:0]            starve_cnt_q, starve_cnt_d;
  logic                  resp_rd_q, resp_rd_d;
  logic                  resp_wr_q, resp_wr_d;

  logic [N_CH-1:0]       rd_elig;
  logic                  wr_elig;
  logic                  rd_any;
  logic [CW-1:0]         sel_ch;
  logic [CW-1:0]         scan_ch;
  logic                  rd_gnt;
  logic                  wr_gnt;
  logic                  ram_en;
  logic                  ram_we;
  logic [ADDR_BITS-1:0]  ram_addr;
  logic [GFX_WORD_W-1:0] ram_dout;
  logic                  unused_addr_bits;

  // The requester answered last cycle still shows valid; mask it out.
  always_comb begin
    rd_elig = rd_valid;
    for (int i = 0; i < N_CH; i++) begin
      if (resp_rd_q && (resp_ch_q == CW'(i))) rd_elig[i] = 1'b0;
    end
    wr_elig = wr_valid && !resp_wr_q;
  end

  always_comb begin
    rd_any  = 1'b0;
    sel_ch  = last_ch_q;
    scan_ch = last_ch_q;
    for (int k = 0; k < N_CH; k++) begin
      scan_ch = (scan_ch == LAST_IDX) ? '0 : scan_ch + CW'(1);
      if (!rd_any && rd_elig[scan_ch]) begin
        rd_any = 1'b1;
        sel_ch = scan_ch;
      end
    end
  end

  // No grants while reset is asserted so the RAM is never written in reset.
  always_comb begin
    wr_gnt   = RSTb && wr_elig && (!rd_any || (starve_cnt_q >= STARVE_LIM));
    rd_gnt   = RSTb && rd_any && !wr_gnt;
    ram_en   = rd_gnt || wr_gnt;
    ram_we   = wr_gnt;
    ram_addr = wr_addr[ADDR_BITS-1:0];
    for (int i = 0; i < N_CH; i++) begin
      if (rd_gnt && (sel_ch == CW'(i))) ram_addr = rd_addr[16*i +: ADDR_BITS];
    end
  end

  always_comb begin
    last_ch_d    = last_ch_q;
    resp_ch_d    = resp_ch_q;
    starve_cnt_d = starve_cnt_q;
    resp_rd_d    = rd_gnt;
    resp_wr_d    = wr_gnt;
    if (rd_gnt) begin
      last_ch_d = sel_ch;
      resp_ch_d = sel_ch;
    end
    if (wr_gnt) begin
      starve_cnt_d = '0;
    end else if (wr_elig && (starve_cnt_q != STARVE_SAT)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      last_ch_q    <= LAST_IDX;
      resp_ch_q    <= '0;
      starve_cnt_q <= '0;
      resp_rd_q    <= 1'b0;
      resp_wr_q    <= 1'b0;
    end else begin
      last_ch_q    <= last_ch_d;
      resp_ch_q    <= resp_ch_d;
      starve_cnt_q <= starve_cnt_d;
      resp_rd_q    <= resp_rd_d;
      resp_wr_q    <= resp_wr_d;
    end
  end

  // Ready is qualified by RSTb so a response pending at reset is dropped.
  always_comb begin
    rd_ready = '0;
    for (int i = 0; i < N_CH; i++) begin
      rd_ready[i] = RSTb && resp_rd_q && (resp_ch_q == CW'(i));
    end
    wr_ready = RSTb && resp_wr_q;
  end

  gfx_spram #(
    .ADDR_BITS (ADDR_BITS)
  ) u_spram (
    .CLK  (CLK),
    .RSTb (RSTb),
    .en   (ram_en),
    .we   (ram_we),
    .addr (ram_addr),
    .din  (wr_data),
    .dout (ram_dout)
  );

  assign rd_data = ram_dout;

  // Address bits above ADDR_BITS are ignored by design.
  assign unused_addr_bits = ^{rd_addr, wr_addr};

endmodule
